irq_priority_encoder: RTL
=========================

Name: irq_priority_encoder

Overview:
- Encoder counterpart to the team's 2-to-4 active-low decoder.
- Takes four active-low request lines, the same one-cold format the decoder drives, and synchronizes them into the clock domain.
- Latches pending requests and presents the highest-priority unmasked one as a 2-bit code with a valid/ack handshake.
- Feeds the LC-3 control unit's interrupt/service-select path.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per request line; legal range 2..4.
- EDGE_MODE, 1, 1 = a falling edge of a synchronized request sets pending; 0 = level-sensitive, pending set every cycle the synchronized request is low.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_n  input  4  active-low request lines, asynchronous to clk; bit i is request i.
- mask  input  4  1 = request i is not eligible for presentation; it is still latched in pending.
- enable  input  1  1 = encoder may start a new presentation.
- ack  input  1  consumer accepts the presented code; sampled only while valid=1.
- valid  output  1  code is valid and held.
- code  output  2  index of the presented request.
- pending  output  4  current pending register, one-hot per request, active-high.

Behaviour:
- Reset: reset_n low asynchronously forces the following, effective immediately, including mid-handshake:
  - all synchronizer flops and edge-history flops to 1 (inactive);
  - pending = 4'b0000, valid = 0, code = 2'b00, FSM = IDLE.
- Synchronizer: req_n[i] passes through SYNC_STAGES flops. sreq_n[i] is the last stage; prev_n[i] is a one-cycle delay of sreq_n[i].
- Set term:
  - EDGE_MODE=1: set[i] = prev_n[i] & ~sreq_n[i].
  - EDGE_MODE=0: set[i] = ~sreq_n[i].
- Clear term: clr[i] = 1 in the cycle ack=1, valid=1 and code==i.
- Pending update: pending[i] <= set[i] | (pending[i] & ~clr[i]). Set wins over a simultaneous clear, so no new edge is lost.
- Priority: eligible = pending & ~mask. The highest index wins (3 > 2 > 1 > 0).
- FSM, 2 states:
  - IDLE: valid=0. If enable=1 and eligible != 0, register code <= highest eligible index and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: valid=1 and code is held stable.
    - Changes to mask, enable or pending have no effect on code while in PRESENT.
    - ack=1 clears pending[code] and returns to IDLE; valid drops after that edge.
    - ack=0 stays in PRESENT indefinitely.
- Handshake:
  - ack while valid=0 is ignored.
  - valid is low for at least one cycle between consecutive grants.
  - Maximum grant rate is one per 2 cycles.
- Latency, SYNC_STAGES=2, EDGE_MODE=1, idle and enabled, req_n[i] falls setup-clean before edge E1:
  - sreq_n low after E2;
  - pending[i]=1 after E3;
  - valid=1 with code=i after E4.
  - In general, valid rises SYNC_STAGES+2 edges after the input is sampled.
- Masked requests stay pending. They are presented once unmasked, provided the FSM is in IDLE with enable=1.
- EDGE_MODE=0 with a request held low: the request re-pends on the cycle after its ack and is re-presented. This is the intended level behaviour.
- A request that pulses shorter than one clock may be missed. This is not an error; sources must hold for ≥2 cycles.

Test Plan:
- Reset, then drive req_n=4'b1011 with mask=0, enable=1, SYNC_STAGES=2 → pending=4'b0100 after 3 edges; valid=1, code=2 after 4 edges; ack one cycle → pending=0 and valid=0 next cycle.
- req_n=4'b0110 simultaneously → code=3 presented first; ack → code=0 presented after exactly 1 idle cycle; ack → pending=0.
- mask=4'b1000, requests on 3 and 1 → code=1; ack; then mask=0 → code=3 presented.
- During PRESENT with code=2, a new falling edge arrives on request 2 in the same cycle as ack → pending[2] stays 1 and code=2 is re-presented after one idle cycle.
- enable=0 with pending=4'b0010 → valid stays 0 for 10 cycles; enable=1 → valid=1, code=1 next edge. Assert reset_n=0 while valid=1 → valid=0 and pending=0 immediately, without waiting for a clock edge.
- EDGE_MODE=0 with req_n[0] held low → code=0 is re-presented after each ack, with a 1-cycle valid gap; release req_n[0] → no further presentations after the final ack.

Source files
------------

// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
//
// Encoder counterpart to the 2-to-4 active-low decoder. Four one-cold
// request lines are synchronized into the clk domain and latched into a
// pending register. The highest-index unmasked pending request is presented
// as a 2-bit code with a valid/ack handshake. The result drives the LC-3
// control unit's interrupt/service-select path.
//
// Parameters:
//   SYNC_STAGES - synchronizer flops per request line (2..4)
//   EDGE_MODE   - 1: a falling edge of a synchronized request sets pending
//                 0: pending is set every cycle the synchronized request is low
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   req_n    in   4  active-low requests, asynchronous to clk
//   mask     in   4  1 = request not eligible for presentation (still latched)
//   enable   in   1  1 = a new presentation may start
//   ack      in   1  consumer accepts the presented code (used only while valid)
//   valid    out  1  code is valid and held
//   code     out  2  index of the presented request
//   pending  out  4  pending register, active-high, one bit per request
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req_n,
  input  logic [3:0] mask,
  input  logic       enable,
  input  logic       ack,
  output logic       valid,
  output logic [1:0] code,
  output logic [3:0] pending
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t     state, state_next;
  logic [1:0] code_next;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sreq_n;
  logic [3:0] prev_n;
  logic [3:0] set;
  logic [3:0] clr;
  logic [3:0] eligible;
  logic [1:0] prio_code;

  // Synchronizer chain plus one extra flop of history for edge detection.
  // Everything resets to 1 so that a line held low through reset is seen as
  // a fresh falling edge once reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= 4'hF;
      end
      prev_n <= 4'hF;
    end else begin
      sync_q[0] <= req_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_n <= sreq_n;
    end
  end

  assign sreq_n = sync_q[SYNC_STAGES-1];

  // Set term: either a high-to-low transition or simply a low level.
  assign set = EDGE_MODE ? (prev_n & ~sreq_n) : ~sreq_n;

  // Clear term: only the bit currently being acknowledged is cleared.
  always_comb begin
    clr = 4'b0000;
    if (valid && ack) begin
      clr[code] = 1'b1;
    end
  end

  // Pending register. Set dominates a simultaneous clear so a new request
  // arriving in the ack cycle is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 4'b0000;
    end else begin
      pending <= set | (pending & ~clr);
    end
  end

  // Fixed priority: highest index wins among unmasked pending requests.
  assign eligible = pending & ~mask;

  always_comb begin
    prio_code = 2'd0;
    if (eligible[3]) begin
      prio_code = 2'd3;
    end else if (eligible[2]) begin
      prio_code = 2'd2;
    end else if (eligible[1]) begin
      prio_code = 2'd1;
    end
  end

  // Handshake FSM next-state logic. The code is captured only on the
  // IDLE->PRESENT transition, so mask/enable/pending changes during PRESENT
  // cannot disturb it. Returning through IDLE guarantees a valid-low gap.
  always_comb begin
    state_next = state;
    code_next  = code;
    case (state)
      IDLE: begin
        if (enable && (eligible != 4'b0000)) begin
          state_next = PRESENT;
          code_next  = prio_code;
        end
      end
      PRESENT: begin
        if (ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state and presented code registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      code  <= 2'b00;
    end else begin
      state <= state_next;
      code  <= code_next;
    end
  end

  // valid decodes straight from the state flop so reset drops it at once.
  assign valid = (state == PRESENT);

endmodule
